iambic_keyer: RTL and testbench
===============================

// Module: iambic_keyer
// PURPOSE
//  Iambic paddle keyer. Converts raw dit/dah paddle contacts into a timed,
//  active-low key line that drives cw_generator's i_key_n. It sits upstream
//  of the cw_generator -> cordic chain. Element timing is set at run time in
//  ms ticks: dit = 1 dot, dah = 3 dots, inter-element space = 1 dot.
// PARAMETERS
//  CLK_HZ    100_000_000  system clock frequency
//  TICK_HZ   1000         timing tick rate; TICK_DIV = CLK_HZ/TICK_HZ, integer, >= 1
//  DOT_W     11           width of i_dotLen (dot length in ticks)
// PORTS
//  i_clk      in   1      system clock
//  i_reset    in   1      synchronous reset, active-high
//  i_enable   in   1      1 = keyer active; 0 = force IDLE, key up
//  i_dit_n    in   1      dit paddle, active-low, asynchronous (raw pin)
//  i_dah_n    in   1      dah paddle, active-low, asynchronous (raw pin)
//  i_swap     in   1      1 = exchange dit/dah paddle roles (synchronous input)
//  i_dotLen   in   DOT_W  dot length in ticks; 0 is treated as 1
//  o_key_n    out  1      key line, 0 = carrier on
//  o_busy     out  1      1 when the FSM is not in IDLE
// BEHAVIOUR
//  - Clocking and reset: one clock. Reset is synchronous and active-high.
//    During reset: o_key_n=1, o_busy=0, FSM=IDLE, sync flops=released,
//    memory clear, counters 0. Asserting reset mid-element drops the key
//    (o_key_n=1) on the next edge.
//  - Input sync: each paddle passes through 2 flops. i_swap is applied after
//    the synchronisers.
//  - FSM states: IDLE, DIT, DAH, GAP. o_key_n=0 only in DIT and DAH.
//  - IDLE -> DIT if dit is pressed, else -> DAH if dah is pressed.
//    If both are pressed in the same cycle, dit wins.
//  - Latency from a paddle pin edge to o_key_n=0 is 3 clocks
//    (2 sync flops + FSM register).
//  - At element entry:
//    - i_dotLen is latched (a change mid-element applies to the next element).
//    - The tick prescaler restarts.
//  - Element durations:
//    - DIT key-down = dotLen*TICK_DIV clocks exactly.
//    - DAH key-down = 3*dotLen*TICK_DIV clocks exactly.
//    - GAP = dotLen*TICK_DIV clocks.
//  - DIT/DAH -> GAP when the element count expires.
//  - GAP end selects the next element:
//    - opposite paddle held -> opposite element;
//    - else same paddle held -> same element;
//    - else IDLE.
//  - Iambic memory (both modes): an opposite-paddle press seen during DIT,
//    DAH or GAP sets an opposite-memory flag. At GAP end, a set flag counts
//    as "opposite held" only under KEYER_MODE_B_EN. The flag clears on
//    element entry.
//  - i_enable=0: FSM forced to IDLE and key up on the next edge; memory is
//    cleared. Paddles are ignored until i_enable=1.
//  - Counters:
//    - prescaler is ceil(log2(TICK_DIV)) bits and wraps at TICK_DIV-1;
//    - element counter is DOT_W+2 bits and cannot overflow (3*max dotLen).
// CONFIGURATION
//  KEYER_MODE_B_EN defined: Curtis mode B. The memorised opposite element is
//    sent even if both paddles are released before GAP end.
//  Undefined: mode A. Only paddle state sampled on the last GAP cycle counts.
//    The memory flag is still kept but has no effect on element selection.
// STRUCTURE
//  - keyer_defs.vh holds the shared constants: state encodings
//    (IDLE=0, DIT=1, DAH=2, GAP=3) and DAH_DOTS=3.
//  - Sub-module keyer_tick_gen: TICK_DIV prescaler with a synchronous restart
//    input; outputs a 1-clock tick pulse.
// TESTING
//  Bench parameters: CLK_HZ=4000, TICK_HZ=1000 (TICK_DIV=4), i_dotLen=3,
//  i_enable=1. With these, a dot lasts 12 clocks.
//  1. Reset held 4 clocks with a paddle pressed -> o_key_n=1 and o_busy=0
//     throughout; key-down starts 3 clocks after reset release.
//  2. Dit held continuously -> o_key_n alternates 12 clocks low / 12 clocks
//     high, starting 3 clocks after the press.
//  3. Dah pulsed low for 5 clocks -> one 36-clock low, a 12-clock gap, then
//     IDLE with o_busy=0.
//  4. Both paddles pressed on the same clock and held -> dit, dah, dit,
//     ... alternating, each separated by a 12-clock gap.
//  5. Dit held; dah tapped for 4 clocks mid-dit; both released before GAP end
//     -> mode B: dit then dah; mode A: dit only. Run the bench in both builds.
//  6. Reset during clock 20 of a dah -> o_key_n=1 on the next edge; the FSM
//     restarts cleanly from IDLE. Repeat with i_enable=0 and with i_swap=1
//     (dit pin produces 36-clock dahs).

Source files
------------

// File: rtl/iambic_keyer_pkg.sv
// Shared definitions for the iambic keyer: FSM state encoding, element
// length in dots, and the prescaler width helper.
package iambic_keyer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIT  = 2'd1,
        ST_DAH  = 2'd2,
        ST_GAP  = 2'd3
    } key_state_e;

    localparam int unsigned DAH_DOTS = 3;

    // A divide-by-one prescaler still needs a 1-bit register.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/iambic_keyer_tick_gen.sv
// Tick prescaler: emits a 1-clock pulse every TICK_DIV clocks. A restart
// zeroes the count so the first tick after restart lands TICK_DIV clocks later.
module iambic_keyer_tick_gen
    import iambic_keyer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned PW = presc_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    // Next count: wrap at the terminal value or on restart.
    always_comb begin
        if (i_restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/iambic_keyer.sv
// Iambic paddle keyer producing an active-low key line.
// Build option: define KEYER_MODE_B_EN for Curtis mode B (memorised opposite
// element is sent even if paddles are released before the gap ends);
// default build is mode A.
//
// state | meaning
// IDLE  | waiting for a paddle, key up
// DIT   | key down for one dot
// DAH   | key down for DAH_DOTS dots
// GAP   | key up for one dot, then pick the next element
module iambic_keyer
    import iambic_keyer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned DOT_W   = 11
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_dit_n,
    input  logic             i_dah_n,
    input  logic             i_swap,
    input  logic [DOT_W-1:0] i_dotLen,
    output logic             o_key_n,
    output logic             o_busy
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned CW       = DOT_W + 2;

    logic             dit_s1_q, dit_s1_d, dit_s2_q, dit_s2_d;
    logic             dah_s1_q, dah_s1_d, dah_s2_q, dah_s2_d;
    key_state_e       state_q, state_d;
    logic             last_dah_q, last_dah_d;
    logic             opp_mem_q, opp_mem_d;
    logic [DOT_W-1:0] dot_len_q, dot_len_d;
    logic [CW-1:0]    elem_cnt_q, elem_cnt_d;
    logic             key_n_q, key_n_d;
    logic             busy_q, busy_d;

    logic             tick, tick_restart;
    logic             dit_p, dah_p, opp_now, same_now, opp_sel;
    logic [DOT_W-1:0] dot_eff;
    logic             start_en, start_dah;

    // Swap is applied after synchronisation; paddles become active-high here.
    assign dit_p    = ~(i_swap ? dah_s2_q : dit_s2_q);
    assign dah_p    = ~(i_swap ? dit_s2_q : dah_s2_q);
    assign opp_now  = last_dah_q ? dit_p : dah_p;
    assign same_now = last_dah_q ? dah_p : dit_p;
    assign dot_eff  = (i_dotLen == '0) ? DOT_W'(1) : i_dotLen;
`ifdef KEYER_MODE_B_EN
    assign opp_sel  = opp_now | opp_mem_q;
`else
    assign opp_sel  = opp_now;
`endif

    // Every state change restarts the prescaler so each phase is whole ticks.
    assign tick_restart = (state_d != state_q);

    iambic_keyer_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_restart (tick_restart),
        .o_tick    (tick)
    );

    // Next-state logic: synchronisers, element sequencing, iambic memory.
    always_comb begin
        dit_s1_d   = i_dit_n;
        dit_s2_d   = dit_s1_q;
        dah_s1_d   = i_dah_n;
        dah_s2_d   = dah_s1_q;
        state_d    = state_q;
        last_dah_d = last_dah_q;
        opp_mem_d  = opp_mem_q;
        dot_len_d  = dot_len_q;
        elem_cnt_d = elem_cnt_q;
        start_en   = 1'b0;
        start_dah  = 1'b0;

        if (!i_enable) begin
            state_d   = ST_IDLE;
            opp_mem_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dit_p) begin
                        start_en = 1'b1;
                    end else if (dah_p) begin
                        start_en  = 1'b1;
                        start_dah = 1'b1;
                    end
                end
                ST_DIT, ST_DAH: begin
                    if (opp_now) opp_mem_d = 1'b1;
                    if (tick) begin
                        if (elem_cnt_q == CW'(1)) begin
                            state_d    = ST_GAP;
                            elem_cnt_d = CW'(dot_len_q);
                        end else begin
                            elem_cnt_d = elem_cnt_q - 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (opp_now) opp_mem_d = 1'b1;
                    if (tick) begin
                        if (elem_cnt_q == CW'(1)) begin
                            if (opp_sel) begin
                                start_en  = 1'b1;
                                start_dah = ~last_dah_q;
                            end else if (same_now) begin
                                start_en  = 1'b1;
                                start_dah = last_dah_q;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            elem_cnt_d = elem_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (start_en) begin
            state_d    = start_dah ? ST_DAH : ST_DIT;
            last_dah_d = start_dah;
            dot_len_d  = dot_eff;
            elem_cnt_d = start_dah ? CW'(DAH_DOTS * dot_eff) : CW'(dot_eff);
            opp_mem_d  = 1'b0;
        end

        key_n_d = ~((state_d == ST_DIT) || (state_d == ST_DAH));
        busy_d  = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dit_s1_q   <= 1'b1;
            dit_s2_q   <= 1'b1;
            dah_s1_q   <= 1'b1;
            dah_s2_q   <= 1'b1;
            state_q    <= ST_IDLE;
            last_dah_q <= 1'b0;
            opp_mem_q  <= 1'b0;
            dot_len_q  <= '0;
            elem_cnt_q <= '0;
            key_n_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            dit_s1_q   <= dit_s1_d;
            dit_s2_q   <= dit_s2_d;
            dah_s1_q   <= dah_s1_d;
            dah_s2_q   <= dah_s2_d;
            state_q    <= state_d;
            last_dah_q <= last_dah_d;
            opp_mem_q  <= opp_mem_d;
            dot_len_q  <= dot_len_d;
            elem_cnt_q <= elem_cnt_d;
            key_n_q    <= key_n_d;
            busy_q     <= busy_d;
        end
    end

    assign o_key_n = key_n_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_iambic_keyer.sv
// Testbench for iambic_keyer: directed paddle sequences, a clock-count
// element model checked every cycle, and literal pulse-length expectations.
// Build with and without KEYER_MODE_B_EN.
module tb_iambic_keyer;

    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        dit_n = 1'b0;
    logic        dah_n = 1'b1;
    logic        swap = 1'b0;
    logic [10:0] dot_len = 11'd3;
    logic        key_n, busy;

    int n_pass = 0;
    int n_total = 0;

    iambic_keyer #(
        .CLK_HZ  (4000),
        .TICK_HZ (1000),
        .DOT_W   (11)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_enable (en),
        .i_dit_n  (dit_n),
        .i_dah_n  (dah_n),
        .i_swap   (swap),
        .i_dotLen (dot_len),
        .o_key_n  (key_n),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: paddles reach the sequencer two clocks late; element phases are
    // counted directly in clocks (dots * TICK_DIV).
    int   m_mode = 0;         // 0 idle, 1 key down, 2 gap
    bit   m_dah = 0, m_mem = 0;
    int   m_left = 0, m_dot = 1;
    logic h1_dit = 1, h2_dit = 1, h1_dah = 1, h2_dah = 1;
    logic exp_key_n = 1, exp_busy = 0;

    task automatic m_start(input bit d);
        m_mode = 1;
        m_dah  = d;
        m_dot  = (dot_len == 0) ? 1 : int'(dot_len);
        m_left = m_dot * TICK_DIV * (d ? 3 : 1);
        m_mem  = 0;
    endtask

    task automatic model_step();
        logic pd, pa, dit, dah, opp, same, osel;
        if (rst) begin
            h1_dit = 1; h2_dit = 1; h1_dah = 1; h2_dah = 1;
            m_mode = 0; m_mem = 0; m_left = 0;
        end else begin
            pd = h2_dit; pa = h2_dah;
            h2_dit = h1_dit; h1_dit = dit_n;
            h2_dah = h1_dah; h1_dah = dah_n;
            dit  = swap ? !pa : !pd;
            dah  = swap ? !pd : !pa;
            opp  = m_dah ? dit : dah;
            same = m_dah ? dah : dit;
            if (!en) begin
                m_mode = 0; m_mem = 0;
            end else if (m_mode == 0) begin
                if (dit) m_start(0);
                else if (dah) m_start(1);
            end else if (m_mode == 1) begin
                if (opp) m_mem = 1;
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2;
                    m_left = m_dot * TICK_DIV;
                end
            end else begin
                if (opp) m_mem = 1;
                m_left--;
                if (m_left == 0) begin
`ifdef KEYER_MODE_B_EN
                    osel = opp | m_mem;
`else
                    osel = opp;
`endif
                    if (osel) m_start(!m_dah);
                    else if (same) m_start(m_dah);
                    else m_mode = 0;
                end
            end
        end
        exp_key_n = (m_mode != 1);
        exp_busy  = (m_mode != 0);
    endtask

    // Per-cycle comparison against the model, 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
            check("cyc_key_n", key_n, exp_key_n);
            check("cyc_busy", busy, exp_busy);
        end
    end

    task automatic wait_for_key(input logic v, output int n);
        n = 0;
        while (key_n !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic measure_run(input logic v, output int n);
        n = 0;
        while (key_n === v && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", n < 400, 1);
        repeat (3) @(negedge clk);
    endtask

    // Dah running; at its 20th key-down clock apply reset (kind 0) or drop
    // enable (kind 1). With swap set, the dit pin is the one producing dahs.
    task automatic dah_abort(input int kind);
        int n;
        if (swap) dit_n = 1'b0; else dah_n = 1'b0;
        wait_for_key(1'b0, n);
        check("abort_lat", n, 3);
        repeat (19) @(negedge clk);
        check("abort_c20_low", key_n, 0);
        if (kind == 0) rst = 1'b1; else en = 1'b0;
        @(negedge clk);
        check("abort_key_up", key_n, 1);
        check("abort_not_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("abort_held_up", key_n, 1);
        if (kind == 0) rst = 1'b0; else en = 1'b1;
        wait_for_key(1'b0, n);
        check("abort_restart_lat", n, (kind == 0) ? 3 : 1);
        measure_run(1'b0, n);
        check("abort_new_dah", n, 36);
        dit_n = 1'b1; dah_n = 1'b1;
        wait_idle();
    endtask

    initial begin
        int n;
        // 1: reset held 4 clocks with dit pressed
        repeat (4) begin
            @(negedge clk);
            check("rst_key_n", key_n, 1);
            check("rst_busy", busy, 0);
        end
        rst = 1'b0;
        wait_for_key(1'b0, n);
        check("rst_release_lat", n, 3);
        dit_n = 1'b1;
        wait_idle();

        // 2: dit held -> 12 low / 12 high alternating
        dit_n = 1'b0;
        wait_for_key(1'b0, n);
        check("dit_lat", n, 3);
        measure_run(1'b0, n); check("dit_low1", n, 12);
        measure_run(1'b1, n); check("dit_gap1", n, 12);
        measure_run(1'b0, n); check("dit_low2", n, 12);
        measure_run(1'b1, n); check("dit_gap2", n, 12);
        dit_n = 1'b1;
        measure_run(1'b0, n); check("dit_low3", n, 12);
        wait_idle();

        // 3: dah pulsed 5 clocks -> one 36-clock element, gap, idle
        dah_n = 1'b0;
        repeat (3) @(negedge clk);
        check("dah_lat_low", key_n, 0);
        repeat (2) @(negedge clk);
        dah_n = 1'b1;
        measure_run(1'b0, n);
        check("dah_low_rest", n, 34);  // 2 of the 36 low clocks already elapsed
        repeat (11) @(negedge clk);
        check("dah_gap_busy", busy, 1);
        @(negedge clk);
        check("dah_then_idle", busy, 0);
        wait_idle();

        // 4: both pressed together -> dit, dah, dit ...
        dit_n = 1'b0; dah_n = 1'b0;
        wait_for_key(1'b0, n);
        check("both_lat", n, 3);
        measure_run(1'b0, n); check("both_dit1", n, 12);
        measure_run(1'b1, n); check("both_gap1", n, 12);
        measure_run(1'b0, n); check("both_dah", n, 36);
        measure_run(1'b1, n); check("both_gap2", n, 12);
        measure_run(1'b0, n); check("both_dit2", n, 12);
        dit_n = 1'b1; dah_n = 1'b1;
        wait_idle();

        // 5: dit held, dah tapped mid-dit, both released before gap end
        dit_n = 1'b0;
        wait_for_key(1'b0, n);
        repeat (4) @(negedge clk);
        dah_n = 1'b0;
        repeat (4) @(negedge clk);
        dah_n = 1'b1; dit_n = 1'b1;
        measure_run(1'b0, n); check("mem_dit_rest", n, 4);
        repeat (12) @(negedge clk);
`ifdef KEYER_MODE_B_EN
        check("memB_dah_start", key_n, 0);
        measure_run(1'b0, n); check("memB_dah_len", n, 36);
`else
        check("memA_key_up", key_n, 1);
        check("memA_idle", busy, 0);
`endif
        wait_idle();

        // dot length: 0 behaves as 1; a mid-element change applies next element
        dit_n = 1'b0;
        wait_for_key(1'b0, n);
        dot_len = 11'd0;
        measure_run(1'b0, n); check("dl_old_dit", n, 12);
        measure_run(1'b1, n); check("dl_old_gap", n, 12);
        measure_run(1'b0, n); check("dl_zero_dit", n, 4);
        dit_n = 1'b1;
        wait_idle();
        dot_len = 11'd3;

        // 6: abort a dah by reset, by disable, and by reset with swapped paddles
        dah_abort(0);
        dah_abort(1);
        swap = 1'b1;
        dah_abort(0);
        swap = 1'b0;

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
